// File: rtl/pixel_frame_source_if.sv
// ----------------------------------------------------------------------------
// pixel_frame_source_if
//   Bundle of the control, frame-RAM read port and pixel-stream signals of
//   pixel_frame_source. Signal names match the face_blur stream naming.
//
//   master : the frame source itself (drives RAM reads and the pixel stream)
//   slave  : the environment (start/hold control, RAM data, stream consumer)
//
//   iSTART    start one frame (sampled only while idle)
//   iHOLD     stall: no new RAM read this cycle
//   oRD_EN    RAM read strobe
//   oRD_ADDR  RAM read address, raster index row*W+col
//   iRD_DATA  RAM read data, valid the cycle after oRD_EN
//   oDVAL     pixel valid
//   oDATA     pixel data (holds while oDVAL=0)
//   oSOF/oEOL/oEOF  first pixel / last of row / last of frame, qualified by oDVAL
//   oBUSY     frame in progress, through the oDONE cycle
//   oDONE     one-cycle pulse after the last pixel
// ----------------------------------------------------------------------------
interface pixel_frame_source_if #(
  parameter int AW = 16
);
  logic          iSTART;
  logic          iHOLD;
  logic          oRD_EN;
  logic [AW-1:0] oRD_ADDR;
  logic [7:0]    iRD_DATA;
  logic          oDVAL;
  logic [7:0]    oDATA;
  logic          oSOF;
  logic          oEOL;
  logic          oEOF;
  logic          oBUSY;
  logic          oDONE;

  modport master (
    input  iSTART, iHOLD, iRD_DATA,
    output oRD_EN, oRD_ADDR, oDVAL, oDATA, oSOF, oEOL, oEOF, oBUSY, oDONE
  );

  modport slave (
    output iSTART, iHOLD, iRD_DATA,
    input  oRD_EN, oRD_ADDR, oDVAL, oDATA, oSOF, oEOL, oEOF, oBUSY, oDONE
  );
endinterface

// File: rtl/pixel_frame_source.sv
// ----------------------------------------------------------------------------
// pixel_frame_source
//   Reads one W x H 8-bit frame from a synchronous frame RAM in raster order
//   and emits it as a pixel stream (one pixel per oDVAL cycle) with SOF/EOL/EOF
//   markers, optional idle cycles between rows and a read-stall input.
//
//   Ports
//     iCLK    clock
//     iRST_N  synchronous active-low reset
//     bus     pixel_frame_source_if.master (control, RAM read port, stream)
//
//   Pipeline: read issued in cycle t -> RAM data in t+1 -> registered pixel
//   visible in t+2. Markers are computed when the read is issued and ride
//   along with it, so they always line up with their pixel.
// ----------------------------------------------------------------------------
module pixel_frame_source #(
  parameter int W        = 210,
  parameter int H        = 300,
  parameter int AW       = 16,
  parameter int LINE_GAP = 0
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  pixel_frame_source_if.master   bus
);

  localparam int CW = $clog2(W);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [CW-1:0] col_q,   col_d;
  logic [RW-1:0] row_q,   row_d;
  logic [GW-1:0] gap_q,   gap_d;

  // Stage 1: read issued last cycle, data arriving on iRD_DATA now.
  logic p1_vld_q, p1_vld_d;
  logic p1_sof_q, p1_sof_d;
  logic p1_eol_q, p1_eol_d;
  logic p1_eof_q, p1_eof_d;

  // Stage 2: registered stream outputs.
  logic       dval_q, dval_d;
  logic [7:0] data_q, data_d;
  logic       sof_q,  sof_d;
  logic       eol_q,  eol_d;
  logic       eof_q,  eof_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic rd_en;
  logic row_end;
  logic frame_end;

  assign row_end   = (col_q == CW'(W - 1));
  assign frame_end = row_end && (row_q == RW'(H - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    col_d    = col_q;
    row_d    = row_q;
    gap_d    = gap_q;
    rd_en    = 1'b0;
    p1_vld_d = 1'b0;
    p1_sof_d = 1'b0;
    p1_eol_d = 1'b0;
    p1_eof_d = 1'b0;

    // Stage 2 always follows stage 1; data holds when no pixel arrives.
    dval_d = p1_vld_q;
    data_d = p1_vld_q ? bus.iRD_DATA : data_q;
    sof_d  = p1_vld_q & p1_sof_q;
    eol_d  = p1_vld_q & p1_eol_q;
    eof_d  = p1_vld_q & p1_eof_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iSTART) begin
          state_d = S_READ;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end

      S_READ: begin
        if (!bus.iHOLD) begin
          rd_en    = 1'b1;
          p1_vld_d = 1'b1;
          p1_sof_d = (addr_q == '0);
          p1_eol_d = row_end;
          p1_eof_d = frame_end;
          addr_d   = addr_q + AW'(1);
          if (row_end) begin
            col_d = '0;
            if (!frame_end) row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (frame_end) begin
            state_d = S_DRAIN;
          end else if (LINE_GAP > 0 && row_end) begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end

      // Counts regardless of iHOLD: the gap is a fixed blanking interval.
      S_GAP: begin
        if (gap_q == GW'(LINE_GAP - 1)) begin
          state_d = S_READ;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      // Last read is in flight; leave once it has moved into stage 2.
      S_DRAIN: begin
        if (!p1_vld_q) state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge iCLK) begin
    // NOTE: the whole pipeline, including the pixel data register, is reset so
    // that a reset mid-frame discards in-flight reads and every output reads 0.
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      gap_q    <= '0;
      p1_vld_q <= 1'b0;
      p1_sof_q <= 1'b0;
      p1_eol_q <= 1'b0;
      p1_eof_q <= 1'b0;
      dval_q   <= 1'b0;
      data_q   <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      gap_q    <= gap_d;
      p1_vld_q <= p1_vld_d;
      p1_sof_q <= p1_sof_d;
      p1_eol_q <= p1_eol_d;
      p1_eof_q <= p1_eof_d;
      dval_q   <= dval_d;
      data_q   <= data_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The read strobe reacts to iHOLD in the same cycle; everything else is
  // driven straight from flops.
  assign bus.oRD_EN   = rd_en;
  assign bus.oRD_ADDR = addr_q;
  assign bus.oDVAL    = dval_q;
  assign bus.oDATA    = data_q;
  assign bus.oSOF     = sof_q;
  assign bus.oEOL     = eol_q;
  assign bus.oEOF     = eof_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oDONE    = done_q;

endmodule

// File: tb/tb_pixel_frame_source.sv
// ----------------------------------------------------------------------------
// tb_pixel_frame_source
//   Three instances on 4-pixel-wide frames with RAM[a] = a+1:
//     a: 4x3, no line gap      b: 4x3, LINE_GAP=2      c: 4x1, LINE_GAP=2
//   Stimulus pushes the expected pixels into per-instance queues; a monitor
//   thread pops and compares whenever oDVAL is seen, tracks the read-address
//   order and records the cycle of every read, pixel and oDONE for the
//   latency/gap checks made after each frame.
// ----------------------------------------------------------------------------
module tb_pixel_frame_source;

  localparam int AW = 4;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] data;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_frame_source_if #(.AW(AW)) if_a ();
  pixel_frame_source_if #(.AW(AW)) if_b ();
  pixel_frame_source_if #(.AW(AW)) if_c ();

  pixel_frame_source #(.W(4), .H(3), .AW(AW), .LINE_GAP(0)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .bus(if_a.master));
  pixel_frame_source #(.W(4), .H(3), .AW(AW), .LINE_GAP(2)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .bus(if_b.master));
  pixel_frame_source #(.W(4), .H(1), .AW(AW), .LINE_GAP(2)) dut_c (
    .iCLK(clk), .iRST_N(rst_n), .bus(if_c.master));

  // Synchronous frame RAMs holding a+1 at address a.
  always @(posedge clk) if (if_a.oRD_EN) if_a.iRD_DATA <= {4'h0, if_a.oRD_ADDR} + 8'd1;
  always @(posedge clk) if (if_b.oRD_EN) if_b.iRD_DATA <= {4'h0, if_b.oRD_ADDR} + 8'd1;
  always @(posedge clk) if (if_c.oRD_EN) if_c.iRD_DATA <= {4'h0, if_c.oRD_ADDR} + 8'd1;

  // Per-instance views so checks can loop over instances.
  logic [2:0] rd_en_w, dval_w, sof_w, eol_w, eof_w, busy_w, done_w;
  logic [3:0] addr_w [3];
  logic [7:0] data_w [3];

  always_comb begin
    rd_en_w   = {if_c.oRD_EN, if_b.oRD_EN, if_a.oRD_EN};
    dval_w    = {if_c.oDVAL,  if_b.oDVAL,  if_a.oDVAL};
    sof_w     = {if_c.oSOF,   if_b.oSOF,   if_a.oSOF};
    eol_w     = {if_c.oEOL,   if_b.oEOL,   if_a.oEOL};
    eof_w     = {if_c.oEOF,   if_b.oEOF,   if_a.oEOF};
    busy_w    = {if_c.oBUSY,  if_b.oBUSY,  if_a.oBUSY};
    done_w    = {if_c.oDONE,  if_b.oDONE,  if_a.oDONE};
    addr_w[0] = if_a.oRD_ADDR;
    addr_w[1] = if_b.oRD_ADDR;
    addr_w[2] = if_c.oRD_ADDR;
    data_w[0] = if_a.oDATA;
    data_w[1] = if_b.oDATA;
    data_w[2] = if_c.oDATA;
  end

  pix_t exp_q [3][$];
  int   exp_addr  [3];
  int   rd_cyc    [3][16];
  int   dval_cyc  [3][16];
  int   n_dval    [3];
  int   n_done    [3];
  int   done_cyc  [3];
  int   start_cyc [3];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int k, input logic v);
    case (k)
      0:       if_a.iSTART = v;
      1:       if_b.iSTART = v;
      default: if_c.iSTART = v;
    endcase
  endtask

  task automatic clear_stats(input int k);
    n_dval[k]   = 0;
    n_done[k]   = 0;
    done_cyc[k] = -1;
    exp_addr[k] = 0;
    for (int i = 0; i < 16; i++) begin
      rd_cyc[k][i]   = -1;
      dval_cyc[k][i] = -1;
    end
  endtask

  // Expected frame of 4-pixel rows: data 01,02,..; EOL on every 4th pixel.
  task automatic push_frame(input int k, input int rows);
    pix_t e;
    for (int i = 0; i < rows * 4; i++) begin
      e.data = 8'(i + 1);
      e.sof  = (i == 0);
      e.eol  = (i % 4 == 3);
      e.eof  = (i == rows * 4 - 1);
      exp_q[k].push_back(e);
    end
  endtask

  task automatic start_frames(input logic [2:0] mask);
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        set_start(k, 1'b1);
        start_cyc[k] = cyc;
      end
    end
    tick();
    for (int k = 0; k < 3; k++) set_start(k, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_w != 3'b000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_w != 3'b000) fail_now("timeout waiting for oBUSY low");
  endtask

  task automatic wait_read5(input int k);
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (rd_en_w[k] && addr_w[k] == 4'd5) found = 1'b1;
      n++;
    end
    if (!found) fail_now("timeout waiting for read of addr 5");
  endtask

  task automatic check_outputs_zero(input int k, input string tag);
    check({tag, "_dval"},  int'(dval_w[k]), 0);
    check({tag, "_rd_en"}, int'(rd_en_w[k]), 0);
    check({tag, "_addr"},  int'(addr_w[k]), 0);
    check({tag, "_data"},  int'(data_w[k]), 0);
    check({tag, "_marks"}, int'({sof_w[k], eol_w[k], eof_w[k]}), 0);
    check({tag, "_busy"},  int'(busy_w[k]), 0);
    check({tag, "_done"},  int'(done_w[k]), 0);
  endtask

  task automatic frame_checks(input int k, input int npix, input int nframes, input int last);
    check($sformatf("n_pixels[%0d]", k), n_dval[k], npix);
    check($sformatf("sb_left[%0d]", k), exp_q[k].size(), 0);
    check($sformatf("n_done[%0d]", k), n_done[k], nframes);
    check($sformatf("start_to_read[%0d]", k), rd_cyc[k][0] - start_cyc[k], 1);
    check($sformatf("read_to_pixel[%0d]", k), dval_cyc[k][0] - rd_cyc[k][0], 2);
    check($sformatf("last_to_done[%0d]", k), done_cyc[k] - dval_cyc[k][last], 1);
  endtask

  task automatic monitor();
    pix_t e;
    pix_t got;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rd_en_w[k]) begin
          check($sformatf("rd_addr[%0d]", k), int'(addr_w[k]), exp_addr[k]);
          rd_cyc[k][addr_w[k]] = cyc;
          exp_addr[k]++;
        end
        got = {sof_w[k], eol_w[k], eof_w[k], data_w[k]};
        if (dval_w[k]) begin
          if (exp_q[k].size() == 0) begin
            fail_now($sformatf("unexpected pixel[%0d] data %02h", k, data_w[k]));
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("pixel[%0d] {sof,eol,eof,data}", k), int'(got), int'(e));
            dval_cyc[k][int'(e.data) - 1] = cyc;
          end
          n_dval[k]++;
        end else begin
          check($sformatf("idle_markers[%0d]", k), int'({sof_w[k], eol_w[k], eof_w[k]}), 0);
        end
        if (done_w[k]) begin
          done_cyc[k] = cyc;
          n_done[k]++;
        end
      end
    end
  endtask

  initial begin
    logic found;
    int   n;

    rst_n = 1'b0;
    if_a.iSTART = 1'b0; if_b.iSTART = 1'b0; if_c.iSTART = 1'b0;
    if_a.iHOLD  = 1'b0; if_b.iHOLD  = 1'b0; if_c.iHOLD  = 1'b0;
    for (int k = 0; k < 3; k++) clear_stats(k);

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero(0, "rst_a");
    check_outputs_zero(1, "rst_b");
    check_outputs_zero(2, "rst_c");
    tick();
    rst_n = 1'b1;
    tick();

    // Plain frame, line-gap frame and single-row frame together
    push_frame(0, 3);
    push_frame(1, 3);
    push_frame(2, 1);
    start_frames(3'b111);
    wait_idle(200);
    frame_checks(0, 12, 1, 11);
    check("a_reads_back_to_back", rd_cyc[0][11] - rd_cyc[0][0], 11);
    check("a_pixels_back_to_back", dval_cyc[0][11] - dval_cyc[0][0], 11);
    frame_checks(1, 12, 1, 11);
    check("b_row0_reads", rd_cyc[1][3] - rd_cyc[1][0], 3);
    check("b_gap_after_3", rd_cyc[1][4] - rd_cyc[1][3], 3);
    check("b_gap_after_7", rd_cyc[1][8] - rd_cyc[1][7], 3);
    check("b_read_span", rd_cyc[1][11] - rd_cyc[1][0], 15);
    check("b_pixel_gap", dval_cyc[1][4] - dval_cyc[1][3], 3);
    frame_checks(2, 4, 1, 3);
    check("c_reads_back_to_back", rd_cyc[2][3] - rd_cyc[2][0], 3);

    // iHOLD for 3 cycles after the read of addr 5
    tick();
    clear_stats(0);
    push_frame(0, 3);
    start_frames(3'b001);
    wait_read5(0);
    tick();
    if_a.iHOLD = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_no_read", int'(rd_en_w[0]), 0);
      check("hold_addr_frozen", int'(addr_w[0]), 6);
      tick();
    end
    if_a.iHOLD = 1'b0;
    wait_idle(200);
    frame_checks(0, 12, 1, 11);
    check("hold_reads_before", rd_cyc[0][5] - rd_cyc[0][0], 5);
    check("hold_read_gap", rd_cyc[0][6] - rd_cyc[0][5], 4);
    check("hold_pixel_hole", dval_cyc[0][6] - dval_cyc[0][5], 4);

    // iSTART mid-frame and in the oDONE cycle ignored; one cycle later accepted
    tick();
    clear_stats(0);
    push_frame(0, 3);
    start_frames(3'b001);
    repeat (4) tick();
    set_start(0, 1'b1);
    @(negedge clk);
    check("busy_mid_frame", int'(busy_w[0]), 1);
    tick();
    set_start(0, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      if (done_w[0]) found = 1'b1;
      n++;
    end
    if (!found) fail_now("timeout waiting for oDONE");
    set_start(0, 1'b1);
    check("busy_in_done_cycle", int'(busy_w[0]), 1);
    tick();
    push_frame(0, 3);
    exp_addr[0]  = 0;
    start_cyc[0] = cyc;
    @(negedge clk);
    check("idle_after_done", int'(busy_w[0]), 0);
    tick();
    set_start(0, 1'b0);
    wait_idle(200);
    frame_checks(0, 24, 2, 11);

    // Reset during row 1
    tick();
    clear_stats(0);
    push_frame(0, 3);
    start_frames(3'b001);
    wait_read5(0);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check_outputs_zero(0, "midrst");
    check("pixels_before_reset", n_dval[0], 5);
    check("no_done_on_reset", n_done[0], 0);
    exp_q[0].delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("idle_after_reset", int'(busy_w[0]), 0);
    check("no_pixels_after_reset", n_dval[0], 5);
    check("no_done_after_reset", n_done[0], 0);
    tick();
    clear_stats(0);
    push_frame(0, 3);
    start_frames(3'b001);
    wait_idle(200);
    frame_checks(0, 12, 1, 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
